// File: rtl/gf2_tc3_mul_sched.sv
// rtl/gf2_tc3_mul_sched.sv - nine limb products of a 3-limb carry-less multiply on one bit-serial shift-XOR engine
// Optional macro TC3_SKIP_ZERO_EN: a product whose a_i or b_j limb is zero takes a single cycle.
module gf2_tc3_mul_sched #(
  parameter int WIDTH = 384
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] c,
  output logic               busy
);
  localparam int LIMB = WIDTH / 3;
  localparam int KW = (LIMB > 1) ? $clog2(LIMB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(LIMB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, c_q, c_d;
  logic [3:0]         p_q, p_d;
  logic [KW-1:0]      k_q, k_d;
  logic [1:0]         i_sel, j_sel;
  logic [LIMB-1:0]    a_limb, b_limb;
  logic               prod_last;
  int                 shift;

  always_comb begin
    i_sel = 2'd0;
    j_sel = 2'd0;
    case (p_q)
      4'd1: j_sel = 2'd1;
      4'd2: j_sel = 2'd2;
      4'd3: i_sel = 2'd1;
      4'd4: begin i_sel = 2'd1; j_sel = 2'd1; end
      4'd5: begin i_sel = 2'd1; j_sel = 2'd2; end
      4'd6: i_sel = 2'd2;
      4'd7: begin i_sel = 2'd2; j_sel = 2'd1; end
      4'd8: begin i_sel = 2'd2; j_sel = 2'd2; end
      default: ;
    endcase
  end

  always_comb begin
    case (i_sel)
      2'd0:    a_limb = a_q[LIMB-1:0];
      2'd1:    a_limb = a_q[2*LIMB-1:LIMB];
      default: a_limb = a_q[3*LIMB-1:2*LIMB];
    endcase
    case (j_sel)
      2'd0:    b_limb = b_q[LIMB-1:0];
      2'd1:    b_limb = b_q[2*LIMB-1:LIMB];
      default: b_limb = b_q[3*LIMB-1:2*LIMB];
    endcase
    shift = LIMB * (int'(i_sel) + int'(j_sel)) + int'(k_q);
  end

  // A skipped product leaves acc untouched: its a_i bits or its b_j term are all zero anyway.
`ifdef TC3_SKIP_ZERO_EN
  assign prod_last = (k_q == K_LAST) ||
                     ((k_q == '0) && ((a_limb == '0) || (b_limb == '0)));
`else
  assign prod_last = (k_q == K_LAST);
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    c_d     = c_q;
    p_d     = p_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          p_d     = '0;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (a_limb[k_q]) acc_d[shift +: LIMB] = acc_q[shift +: LIMB] ^ b_limb;
        if (prod_last) begin
          k_d = '0;
          if (p_q == 4'd8) begin
            p_d     = '0;
            c_d     = acc_d;
            state_d = DONE;
          end else begin
            p_d = p_q + 4'd1;
          end
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      c_q     <= '0;
      p_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      p_q     <= p_d;
      k_q     <= k_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign c         = c_q;

endmodule

// File: tb/tb_gf2_tc3_mul_sched.sv
// tb/tb_gf2_tc3_mul_sched.sv - directed and random checks of gf2_tc3_mul_sched against a plain carry-less multiply
module tb_gf2_tc3_mul_sched;
  localparam int W = 384;
  localparam int L = W / 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a, b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] c;
  logic           busy;

  int n_cmp = 0;
  int n_err = 0;

  gf2_tc3_mul_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .c(c), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] clmul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++)
      if (x[i]) r = r ^ ({{W{1'b0}}, y} << i);
    return r;
  endfunction

  function automatic int lat_model(input logic [W-1:0] x, input logic [W-1:0] y);
    int l;
    l = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
`ifdef TC3_SKIP_ZERO_EN
        l += ((x[i*L +: L] == '0) || (y[j*L +: L] == '0)) ? 1 : L;
`else
        l += L;
`endif
      end
    return l;
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    for (int i = 0; i < 3; i++) begin
      if ($urandom_range(3) == 0) v[i*L +: L] = '0;
      else v[i*L +: L] = {$urandom, $urandom, $urandom, $urandom};
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for out_valid; returns the number of edges since the acceptance edge.
  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 3000) begin
      step();
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input bit hold_ready);
    int n;
    logic [2*W-1:0] exp_c;
    exp_c = clmul(av, bv);
    chk({tag, " in_ready before"}, (2*W)'(in_ready), (2*W)'(1));
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    out_ready = !hold_ready;
    step();
    in_valid = 1'b0;
    a = rand_op();
    b = rand_op();
    chk({tag, " busy after accept"}, (2*W)'(busy), (2*W)'(1));
    chk({tag, " in_ready after accept"}, (2*W)'(in_ready), (2*W)'(0));
    wait_done(n);
    chk({tag, " latency"}, (2*W)'(n), (2*W)'(lat_model(av, bv)));
    chk({tag, " c"}, c, exp_c);
    if (!hold_ready) begin
      step();
      chk({tag, " in_ready after handshake"}, (2*W)'(in_ready), (2*W)'(1));
      chk({tag, " out_valid after handshake"}, (2*W)'(out_valid), (2*W)'(0));
      chk({tag, " c held"}, c, exp_c);
    end
  endtask

  initial begin
    int n;
    logic [W-1:0] a1, b1, a2, b2, one;

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", (2*W)'(in_ready), (2*W)'(1));
    chk("reset out_valid", (2*W)'(out_valid), (2*W)'(0));
    chk("reset busy", (2*W)'(busy), (2*W)'(0));
    chk("reset c", c, '0);
    rst = 1'b1;
    step();

    one = '0; one[0] = 1'b1;
    run_op("min", one, one, 1'b0);
    chk("min c literal", c, (2*W)'(1));
    run_op("clmul3", (W)'(3), (W)'(3), 1'b0);
    chk("clmul3 literal", c, (2*W)'(5));
    a1 = '0; a1[W-1] = 1'b1;
    run_op("top", a1, a1, 1'b0);
    chk("top bit 766", (2*W)'(c[2*W-2]), (2*W)'(1));

    // Backpressure: DONE stalls with c stable and new operands refused.
    run_op("bp", (W)'(15), (W)'(3), 1'b1);
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      a = rand_op();
      b = rand_op();
      step();
      chk("bp c stable", c, (2*W)'(17));
      chk("bp out_valid", (2*W)'(out_valid), (2*W)'(1));
      chk("bp in_ready", (2*W)'(in_ready), (2*W)'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp release in_ready", (2*W)'(in_ready), (2*W)'(1));
    chk("bp release c", c, (2*W)'(17));

    // Back-to-back with in_valid held high.
    a1 = rand_op(); b1 = rand_op(); a2 = rand_op(); b2 = rand_op();
    b2[0] = 1'b1; a2[0] = 1'b1;
    in_valid = 1'b1; a = a1; b = b1; out_ready = 1'b1;
    step();
    a = a2; b = b2;
    wait_done(n);
    chk("b2b first latency", (2*W)'(n), (2*W)'(lat_model(a1, b1)));
    chk("b2b first c", c, clmul(a1, b1));
    n = 0;
    while (!busy && n < 10) begin
      step();
      n++;
    end
    chk("b2b accept gap", (2*W)'(n), (2*W)'(2));
    in_valid = 1'b0;
    a = rand_op(); b = rand_op();
    wait_done(n);
    chk("b2b second latency", (2*W)'(n), (2*W)'(lat_model(a2, b2)));
    chk("b2b second c", c, clmul(a2, b2));
    step();

    // Reset in the middle of a run discards it.
    a1 = '1; b1 = '1;
    in_valid = 1'b1; a = a1; b = b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    chk("midrun busy before reset", (2*W)'(busy), (2*W)'(1));
    rst = 1'b0;
    #1;
    chk("midrun reset out_valid", (2*W)'(out_valid), (2*W)'(0));
    chk("midrun reset c", c, '0);
    chk("midrun reset in_ready", (2*W)'(in_ready), (2*W)'(1));
    chk("midrun reset busy", (2*W)'(busy), (2*W)'(0));
    step();
    rst = 1'b1;
    step();
    run_op("post reset", (W)'(5), (W)'(7), 1'b0);
    chk("post reset literal", c, (2*W)'(27));

    for (int t = 0; t < 20; t++) begin
      a1 = rand_op();
      b1 = rand_op();
      run_op($sformatf("rand%0d", t), a1, b1, t[0]);
      if (t[0]) begin
        step();
        step();
        chk("rand stall c", c, clmul(a1, b1));
        out_ready = 1'b1;
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
